// File: rtl/bdm_target.sv
// BKGD single-wire BDM target: decodes host-timed bits, answers SYNC, runs a
// small command subset against a byte-wide memory port, and drives replies.
module bdm_target #(
  parameter int unsigned CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bkgd_in,
  output logic        bkgd_oe,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  output logic        bgnd_active,
  output logic [7:0]  last_cmd
);

  localparam int unsigned LOW_MAX  = 256 * CYC;
  localparam int unsigned T_SYNC   = 128 * CYC;
  localparam int unsigned T_SAMPLE = 10 * CYC;
  localparam int unsigned T_HOLD   = 13 * CYC;
  localparam int unsigned T_SDLY   = 16 * CYC;
  localparam int unsigned T_SRESP  = 128 * CYC;
  localparam int unsigned LW       = $clog2(LOW_MAX + 1);
  localparam int unsigned TW       = $clog2(T_SRESP + 1);

  typedef enum logic [3:0] {
    IDLE, RX_AH, RX_AL, RX_DATA, RD, RD_WAIT, WR, TX,
    SYNC_WAIT, SYNC_DLY, SYNC_RESP
  } state_t;

  state_t      state;
  logic        bkgd_s1, bkgd_s, bkgd_d;
  logic [1:0]  mask_cnt;
  logic [LW-1:0] lowcnt;
  logic [TW-1:0] tmr;
  logic        win;
  logic [2:0]  bitcnt;
  logic [6:0]  sr;
  logic [7:0]  addr_hi;
  logic [7:0]  txbyte;

  logic line_fall, line_rise, fall, sync_hit, sample, tx_end;
  logic [7:0] rx_next;

  always_comb begin
    line_fall = bkgd_d & ~bkgd_s;
    line_rise = ~bkgd_d & bkgd_s;
    fall      = line_fall & ~bkgd_oe & (mask_cnt == 2'd0);
    // Fires on the single cycle lowcnt crosses the threshold, so a saturated
    // count left over from an earlier SYNC cannot retrigger.
    sync_hit  = ~bkgd_s & ~line_fall & (state != SYNC_RESP) &
                (lowcnt == LW'(T_SYNC - 1));
    sample    = win & (tmr == TW'(T_SAMPLE - 1));
    tx_end    = win & (tmr == TW'(T_HOLD - 1));
    rx_next   = {sr, bkgd_s};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bkgd_s1     <= 1'b1;
      bkgd_s      <= 1'b1;
      bkgd_d      <= 1'b1;
      mask_cnt    <= '0;
      lowcnt      <= '0;
      tmr         <= '0;
      win         <= 1'b0;
      bitcnt      <= '0;
      sr          <= '0;
      addr_hi     <= '0;
      txbyte      <= '0;
      bkgd_oe     <= 1'b0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      bgnd_active <= 1'b0;
      last_cmd    <= '0;
    end else begin
      bkgd_s1 <= bkgd_in;
      bkgd_s  <= bkgd_s1;
      bkgd_d  <= bkgd_s;

      if (bkgd_oe)               mask_cnt <= 2'd2;
      else if (mask_cnt != 2'd0) mask_cnt <= mask_cnt - 2'd1;

      // Our own SYNC response holds the line low; it must not count as a host SYNC.
      if (line_fall)
        lowcnt <= '0;
      else if (!bkgd_s && state != SYNC_RESP && lowcnt != LW'(LOW_MAX))
        lowcnt <= lowcnt + 1'b1;

      tmr    <= tmr + 1'b1;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;

      if (sync_hit) begin
        state   <= SYNC_WAIT;
        bkgd_oe <= 1'b0;
        win     <= 1'b0;
        bitcnt  <= '0;
      end else begin
        case (state)
          IDLE, RX_AH, RX_AL, RX_DATA: begin
            if (fall) begin
              win <= 1'b1;
              tmr <= '0;
            end else if (sample) begin
              win    <= 1'b0;
              sr     <= rx_next[6:0];
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                case (state)
                  IDLE: begin
                    last_cmd <= rx_next;
                    case (rx_next)
                      8'h90: bgnd_active <= 1'b1;
                      8'h08: bgnd_active <= 1'b0;
                      8'hE4: begin
                        txbyte <= {1'b1, bgnd_active, 6'b0};
                        state  <= TX;
                      end
                      8'hC4: state <= RX_DATA;
                      8'hE0, 8'hC0: state <= RX_AH;
                      default: ;
                    endcase
                  end
                  RX_AH: begin
                    addr_hi <= rx_next;
                    state   <= RX_AL;
                  end
                  RX_AL: begin
                    mem_addr <= {addr_hi, rx_next};
                    if (last_cmd == 8'hE0) begin
                      mem_rd <= 1'b1;
                      state  <= RD;
                    end else begin
                      state <= RX_DATA;
                    end
                  end
                  default: begin
                    if (last_cmd == 8'hC4) begin
                      bgnd_active <= rx_next[6];
                      state       <= IDLE;
                    end else begin
                      mem_wdata <= rx_next;
                      mem_wr    <= 1'b1;
                      state     <= WR;
                    end
                  end
                endcase
              end
            end
          end
          RD:      state <= RD_WAIT;
          RD_WAIT: begin
            txbyte <= mem_rdata;
            state  <= TX;
          end
          WR:      state <= IDLE;
          TX: begin
            if (fall) begin
              win     <= 1'b1;
              tmr     <= '0;
              bkgd_oe <= ~txbyte[7];
            end else if (tx_end) begin
              win     <= 1'b0;
              bkgd_oe <= 1'b0;
              txbyte  <= {txbyte[6:0], 1'b0};
              bitcnt  <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) state <= IDLE;
            end
          end
          SYNC_WAIT: begin
            if (line_rise) begin
              state <= SYNC_DLY;
              tmr   <= '0;
            end
          end
          SYNC_DLY: begin
            // Rise is seen one clk after the synchronized edge, hence the -2.
            if (tmr == TW'(T_SDLY - 2)) begin
              bkgd_oe <= 1'b1;
              tmr     <= '0;
              state   <= SYNC_RESP;
            end
          end
          SYNC_RESP: begin
            if (tmr == TW'(T_SRESP - 1)) begin
              bkgd_oe <= 1'b0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bdm_target.sv
// Directed bench for bdm_target: a host model drives BKGD with timed pulses and
// reads replies back over the wired-AND line.
module tb_bdm_target;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_low = 1'b0;
  logic        bkgd_in, bkgd_oe, mem_rd, mem_wr, bgnd_active;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  mem_wdata, last_cmd;

  int unsigned n_tests = 0, n_fail = 0;
  int unsigned rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [15:0] wr_addr = '0, rd_addr = '0;
  logic [7:0]  wr_data = '0;

  always #5 clk = ~clk;
  assign bkgd_in = ~(host_low | bkgd_oe);

  bdm_target #(.CYC(4)) dut (
    .clk(clk), .rst(rst), .bkgd_in(bkgd_in), .bkgd_oe(bkgd_oe),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .bgnd_active(bgnd_active),
    .last_cmd(last_cmd)
  );

  always @(posedge clk)
    if (mem_rd) mem_rdata <= (mem_addr == 16'h00FF) ? 8'h5A : 8'h00;

  always @(negedge clk) begin
    if (mem_rd) begin rd_cnt++; rd_addr = mem_addr; end
    if (mem_wr) begin wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata; end
    if (mem_rd && mem_wr) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    host_low = 1'b1;
    repeat (b ? 16 : 52) @(negedge clk);
    host_low = 1'b0;
    repeat (b ? 64 : 28) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic read_bit(output logic b, output logic drove);
    b = 1'b0;
    drove = 1'b0;
    host_low = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 15) host_low = 1'b0;
      if (bkgd_oe) drove = 1'b1;
      if (k == 39) b = bkgd_in;
    end
  endtask

  task automatic read_byte(output logic [7:0] v, output logic [7:0] drove);
    logic b, d;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b, d);
      v[i] = b;
      drove[i] = d;
    end
  endtask

  task automatic wait_oe(input int lim, output int d);
    d = 0;
    while (!bkgd_oe && d < lim) begin
      @(negedge clk);
      d++;
    end
    if (!bkgd_oe) d = 999;
  endtask

  task automatic oe_width(output int w);
    w = 0;
    while (bkgd_oe && w < 1000) begin
      @(negedge clk);
      w++;
    end
  endtask

  initial begin
    logic [7:0] v, dr;
    logic b, d1;
    int d, w;
    int unsigned r0, w0;

    repeat (4) @(negedge clk);
    check("rst_oe", bkgd_oe, 0);
    check("rst_rd", mem_rd, 0);
    check("rst_wr", mem_wr, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_bgnd", bgnd_active, 0);
    check("rst_last_cmd", last_cmd, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // SYNC: 600 clk low, reply 64 (+/-3) clk after release, 512 clk wide
    host_low = 1'b1;
    repeat (600) @(negedge clk);
    host_low = 1'b0;
    wait_oe(200, d);
    check("sync_delay_in_range", (d >= 61 && d <= 67), 1);
    oe_width(w);
    check("sync_width", w, 512);
    repeat (20) @(negedge clk);

    // BACKGROUND then READ_STATUS
    send_byte(8'h90);
    check("bgnd_set", bgnd_active, 1);
    send_byte(8'hE4);
    check("last_cmd_e4", last_cmd, 8'hE4);
    read_byte(v, dr);
    check("status_bgnd", v, 8'hC0);

    // WRITE_BYTE
    r0 = rd_cnt; w0 = wr_cnt;
    send_byte(8'hC0); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
    repeat (10) @(negedge clk);
    check("wr_pulses", wr_cnt - w0, 1);
    check("wr_addr", wr_addr, 16'h1234);
    check("wr_data", wr_data, 8'hA5);
    check("wr_no_rd", rd_cnt - r0, 0);

    // READ_BYTE
    r0 = rd_cnt; w0 = wr_cnt;
    send_byte(8'hE0); send_byte(8'h00); send_byte(8'hFF);
    read_byte(v, dr);
    check("rd_pulses", rd_cnt - r0, 1);
    check("rd_addr", rd_addr, 16'h00FF);
    check("rd_data", v, 8'h5A);
    check("rd_drive_pattern", dr, 8'hA5);
    check("rd_no_wr", wr_cnt - w0, 0);

    // GO, then WRITE_BYTE aborted by SYNC
    send_byte(8'h08);
    check("bgnd_clear", bgnd_active, 0);
    w0 = wr_cnt;
    send_byte(8'hC0); send_byte(8'h12);
    host_low = 1'b1;
    repeat (600) @(negedge clk);
    host_low = 1'b0;
    wait_oe(200, d);
    check("abort_sync_resp", (d >= 61 && d <= 67), 1);
    oe_width(w);
    check("abort_sync_width", w, 512);
    check("abort_no_wr", wr_cnt - w0, 0);
    repeat (20) @(negedge clk);
    send_byte(8'hE4);
    read_byte(v, dr);
    check("abort_status", v, 8'h80);

    // Unknown command is discarded
    send_byte(8'h55);
    check("last_cmd_55", last_cmd, 8'h55);
    send_byte(8'hE4);
    read_byte(v, dr);
    check("unknown_status", v, 8'h80);

    // WRITE_CONTROL sets bgnd_active from data bit 6
    send_byte(8'hC4); send_byte(8'h40);
    check("wctl_bgnd", bgnd_active, 1);

    // Reset in the middle of TX while the target drives a 0 bit
    send_byte(8'hE4);
    read_bit(b, d1);
    check("tx_bit0", b, 1);
    read_bit(b, d1);
    check("tx_bit1", b, 1);
    host_low = 1'b1;
    wait_oe(10, d);
    check("tx_oe_within_3", (d <= 3), 1);
    rst = 1'b1;
    host_low = 1'b0;
    @(negedge clk);
    check("midtx_rst_oe", bkgd_oe, 0);
    check("midtx_rst_bgnd", bgnd_active, 0);
    check("midtx_rst_last_cmd", last_cmd, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    send_byte(8'hE4);
    read_byte(v, dr);
    check("post_rst_status", v, 8'h80);

    check("rd_wr_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
